inst_encoder: RTL and testbench

//  Inverse of the immediate-generation path: packs opcode/register/funct fields plus a 32-bit

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/inst_pack.sv | 80 ++++++++
 rtl/inst_encoder.sv | 180 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I constants: base opcodes and instruction format classification.
//   Used by the instruction encoder and by the immediate generator so both sides
//   agree on which opcode implies which immediate layout.
// Contents
//   OP_*    7-bit major opcodes (inst[6:0])
//   fmt_e   instruction format class
//   fmt_of  opcode -> format; unknown opcodes map to FMT_X
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_JAL:                    f = FMT_J;
      OP_JALR, OP_IMM, OP_LOAD:  f = FMT_I;
      OP_LUI, OP_AUIPC:          f = FMT_U;
      OP_STORE:                  f = FMT_S;
      OP_BRANCH:                 f = FMT_B;
      OP_REG:                    f = FMT_R;
      default:                   f = FMT_X;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
//   Combinational RV32I field packer: places opcode, register, funct and
//   immediate fields into a 32-bit instruction word. Immediate bits that do not
//   fit the selected format are dropped.
//   Build option: IMM_RANGE_CHECK_EN -- when defined, o_imm_err flags an
//   immediate that cannot be represented exactly in the selected format; when
//   undefined, no check logic is built and o_imm_err is 0.
// Ports
//   i_opcode   7   major opcode, selects format
//   i_rd       5   destination register
//   i_rs1      5   source register 1
//   i_rs2      5   source register 2
//   i_funct3   3   funct3 field
//   i_funct7   7   funct7 field (R-type only)
//   i_imm      32  signed immediate (byte offset for B/J, full value for U)
//   o_inst_code 32 encoded instruction
//   o_imm_err  1   immediate out of range for the selected format
// -----------------------------------------------------------------------------
module inst_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst_code,
  output logic        o_imm_err
);

  fmt_e w_fmt;

  assign w_fmt = fmt_of(i_opcode);

  always_comb begin
    o_inst_code = {25'b0, i_opcode};
    case (w_fmt)
      FMT_I: o_inst_code = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S: o_inst_code = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_inst_code = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_inst_code = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_inst_code = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                            i_rd, i_opcode};
      FMT_R: o_inst_code = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      default: o_inst_code = {25'b0, i_opcode};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits an N-bit signed field when all bits from the field's
  // sign bit upward are identical.
  logic w_bad12;
  logic w_bad13;
  logic w_bad21;
  logic w_bad_u;

  assign w_bad12 = !((&i_imm[31:11]) || !(|i_imm[31:11]));
  assign w_bad13 = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
  assign w_bad21 = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
  assign w_bad_u = |i_imm[11:0];

  always_comb begin
    o_imm_err = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: o_imm_err = w_bad12;
      FMT_B:        o_imm_err = w_bad13;
      FMT_J:        o_imm_err = w_bad21;
      FMT_U:        o_imm_err = w_bad_u;
      default:      o_imm_err = 1'b0;
    endcase
  end
`else
  assign o_imm_err = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Streams RV32I instruction words from field requests toward an instruction
//   memory write port. Each accepted request is packed by inst_pack, buffered
//   in a 2-entry (output register + skid) pipeline and handed out with a
//   sequential byte address bound at output time.
//   Build option: IMM_RANGE_CHECK_EN -- when defined, per-word immediate range
//   errors are reported on imm_err and accumulated in err_sticky; when
//   undefined, both are tied 0 and err_clr is ignored.
// Parameters
//   BASE_ADDR  byte address of the first word after reset / addr_clr
//   ADDR_W     width of out_addr (wraps modulo 2**ADDR_W)
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   request valid           in_ready   can accept (registered)
//   opcode/rd/rs1/rs2/funct3/funct7/imm   request fields
//   addr_clr   reload address counter  err_clr    clear err_sticky
//   out_valid  output word valid       out_ready  consumer accepts
//   inst_code  encoded word            out_addr   byte address of inst_code
//   imm_err    range error of word     err_sticky accumulated range errors
// -----------------------------------------------------------------------------
module inst_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_clr,
  input  logic              err_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_code,
  output logic [ADDR_W-1:0] out_addr,
  output logic              imm_err,
  output logic              err_sticky
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic [31:0]       w_pack_code;
  logic              w_pack_err;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [31:0]       r_out_code;
  logic              r_skid_valid;
  logic [31:0]       r_skid_code;
  logic [ADDR_W-1:0] r_addr;

  logic              w_acc;
  logic              w_pop;
  logic              w_out_load_in;
  logic              w_out_load_skid;
  logic              w_skid_load;
  logic              w_out_valid_nxt;
  logic              w_skid_valid_nxt;

  inst_pack u_pack (
    .i_opcode    (opcode),
    .i_rd        (rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_funct3    (funct3),
    .i_funct7    (funct7),
    .i_imm       (imm),
    .o_inst_code (w_pack_code),
    .o_imm_err   (w_pack_err)
  );

  // in_ready is the registered complement of the next skid occupancy, so a
  // request is only ever accepted while the skid is empty. With that
  // invariant the buffer moves reduce to three load enables: the output
  // register takes the skid word on a pop when the skid is full, otherwise
  // the new word whenever it is free or being emptied; the new word parks in
  // the skid only when the output register is full and stalled.
  always_comb begin
    w_acc           = in_valid && r_in_ready;
    w_pop           = r_out_valid && out_ready;
    w_out_load_skid = r_skid_valid && w_pop;
    w_out_load_in   = w_acc && (!r_out_valid || w_pop);
    w_skid_load     = w_acc && r_out_valid && !w_pop;
    w_out_valid_nxt = r_skid_valid || w_acc || (r_out_valid && !w_pop);
    w_skid_valid_nxt = r_skid_valid ? !w_pop : w_skid_load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_code   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_code  <= '0;
    end else begin
      r_in_ready   <= !w_skid_valid_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_out_load_skid) begin
        r_out_code <= r_skid_code;
      end else if (w_out_load_in) begin
        r_out_code <= w_pack_code;
      end
      if (w_skid_load) begin
        r_skid_code <= w_pack_code;
      end
    end
  end

  // addr_clr wins over a same-cycle advance; the word handed over in that
  // cycle has already been presented with its old address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= BASE;
    end else if (addr_clr) begin
      r_addr <= BASE;
    end else if (w_pop) begin
      r_addr <= r_addr + STEP;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic r_out_err;
  logic r_skid_err;
  logic r_sticky;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_err  <= 1'b0;
      r_skid_err <= 1'b0;
    end else begin
      if (w_out_load_skid) begin
        r_out_err <= r_skid_err;
      end else if (w_out_load_in) begin
        r_out_err <= w_pack_err;
      end
      if (w_skid_load) begin
        r_skid_err <= w_pack_err;
      end
    end
  end

  // A set from a word being handed over beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sticky <= 1'b0;
    end else if (w_pop && r_out_err) begin
      r_sticky <= 1'b1;
    end else if (err_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign imm_err    = r_out_err;
  assign err_sticky = r_sticky;
`else
  logic w_unused;

  assign w_unused   = ^{w_pack_err, err_clr};
  assign imm_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign inst_code = r_out_code;
  assign out_addr  = r_addr;

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//   Self-checking bench for inst_encoder. A behavioural model (queue of
//   expected words, address and sticky flag) is advanced once per cycle from
//   the driven inputs; encodings and range checks are computed arithmetically
//   from the RV32I field rules.
//   Follows IMM_RANGE_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

  localparam logic [31:0] TB_BASE = 32'h0000_00F0;
  localparam int unsigned TB_AW   = 8;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             addr_clr;
  logic             err_clr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      inst_code;
  logic [TB_AW-1:0] out_addr;
  logic             imm_err;
  logic             err_sticky;

  inst_encoder #(
    .BASE_ADDR (TB_BASE),
    .ADDR_W    (TB_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .addr_clr   (addr_clr),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inst_code  (inst_code),
    .out_addr   (out_addr),
    .imm_err    (imm_err),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] code;
    bit          err;
  } word_t;

  word_t       q[$];
  int unsigned m_addr;
  bit          m_sticky;
  bit          m_live;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_code(input logic [6:0] op, input logic [4:0] rd_v,
                                           input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                           input logic [2:0] f3_v, input logic [6:0] f7_v,
                                           input logic [31:0] im);
    logic [31:0] o, d, s1, s2, f3, f7;
    o  = 32'(op);
    d  = 32'(rd_v) << 7;
    s1 = 32'(rs1_v) << 15;
    s2 = 32'(rs2_v) << 20;
    f3 = 32'(f3_v) << 12;
    f7 = 32'(f7_v) << 25;
    case (op)
      7'h13, 7'h03, 7'h67: return ((im & 32'hFFF) << 20) | s1 | f3 | d | o;
      7'h23: return (((im >> 5) & 32'h7F) << 25) | s2 | s1 | f3 | ((im & 32'h1F) << 7) | o;
      7'h63: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | s2 | s1 | f3
                    | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
      7'h37, 7'h17: return (im & 32'hFFFF_F000) | d | o;
      7'h6F: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | d | o;
      7'h33: return f7 | s2 | s1 | f3 | d | o;
      default: return o;
    endcase
  endfunction

  function automatic bit ref_err(input logic [6:0] op, input logic [31:0] im);
    int s;
    bit e;
    s = $signed(im);
    case (op)
      7'h13, 7'h03, 7'h67, 7'h23: e = (s < -2048) || (s > 2047);
      7'h63: e = (s < -4096) || (s > 4095) || ((im & 32'h1) != 0);
      7'h6F: e = (s < -1048576) || (s > 1048575) || ((im & 32'h1) != 0);
      7'h37, 7'h17: e = (im & 32'hFFF) != 0;
      default: e = 1'b0;
    endcase
    return RC && e;
  endfunction

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(m_live && (q.size() < 2)));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("inst_code", inst_code, q[0].code);
      chk("out_addr", 32'(out_addr), m_addr);
      chk("imm_err", 32'(imm_err), 32'(q[0].err));
    end
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
  endtask

  // Called at a falling edge with inputs already driven; models the next
  // rising edge, then checks the DUT at the following falling edge.
  task automatic tick();
    bit    acc, pop;
    word_t w;
    acc = in_valid && m_live && (q.size() < 2);
    pop = (q.size() != 0) && out_ready;
    if (pop) begin
      w = q.pop_front();
      if (w.err) m_sticky = 1'b1;
      else if (err_clr) m_sticky = 1'b0;
    end else if (err_clr) begin
      m_sticky = 1'b0;
    end
    if (addr_clr) m_addr = TB_BASE % 256;
    else if (pop) m_addr = (m_addr + 4) % 256;
    if (acc) begin
      w.code = ref_code(opcode, rd, rs1, rs2, funct3, funct7, imm);
      w.err  = ref_err(opcode, imm);
      q.push_back(w);
    end
    m_live = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; addr_clr = 1'b0; err_clr = 1'b0;
    q.delete();
    m_addr = TB_BASE % 256; m_sticky = 1'b0; m_live = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_inst_code", inst_code, 32'h0);
    chk("rst_out_addr", 32'(out_addr), TB_BASE % 256);
    chk("rst_imm_err", 32'(imm_err), 32'(0));
    chk("rst_err_sticky", 32'(err_sticky), 32'(0));
    reset = 1'b1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                            input logic [4:0] rs2_v, input logic [2:0] f3_v, input logic [31:0] im);
    opcode = op; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; funct3 = f3_v; funct7 = 7'h0; imm = im;
  endtask

  task automatic direct(input string tag, input logic [6:0] op, input logic [4:0] rd_v,
                        input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3_v,
                        input logic [31:0] im, input logic [31:0] exp_code, input bit exp_err);
    set_fields(op, rd_v, rs1_v, rs2_v, f3_v, im);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk({tag, "_code"}, inst_code, exp_code);
    chk({tag, "_err"}, 32'(imm_err), 32'(exp_err));
    in_valid = 1'b0;
    tick();
  endtask

  task automatic rand_fields();
    logic [6:0] ops[10];
    ops = '{7'h6F, 7'h67, 7'h13, 7'h03, 7'h37, 7'h17, 7'h23, 7'h63, 7'h33, 7'h00};
    opcode = ops[$urandom_range(0, 9)];
    if (opcode == 7'h00) opcode = 7'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      1: imm = $urandom;
      2: imm = $urandom & 32'hFFFF_F000;
      default: imm = 32'($urandom_range(0, 4000)) & 32'hFFFF_FFFE;
    endcase
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    set_fields(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 32'h0);
    do_reset();
    tick();

    direct("addi_m1", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    direct("beq_m4",  7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    direct("jal_8",   7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0);
    direct("lui",     7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    direct("addi_2048", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, RC);
    chk("sticky_after_2048", 32'(err_sticky), 32'(RC));
    direct("beq_3", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 32'h0020_8163, RC);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("sticky_cleared", 32'(err_sticky), 32'(0));

    // Stall with three back-to-back requests, then drain.
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 32'(i));
      tick();
    end
    chk("full_in_ready", 32'(in_ready), 32'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Continuous streaming: one word per cycle with no bubbles.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_fields();
      tick();
    end
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 500; i++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      addr_clr  = ($urandom_range(0, 31) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    addr_clr = 1'b0; err_clr = 1'b0;

    // Reset asserted mid-stream with two words buffered.
    out_ready = 1'b0; in_valid = 1'b1;
    while (q.size() < 2) begin
      rand_fields();
      tick();
      if (n_chk > 20000) break;
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    do_reset();
    tick();
    set_fields(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 32'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("post_rst_addr", 32'(out_addr), TB_BASE % 256);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
